pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Sequences the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WR) and the PC of the 5-stage CPU.
//   - Generates per-stage enable and flush (bubble) strobes for load-use stalls, taken-branch flushes
//     and multi-cycle data-memory waits.
//   - Halts the pipeline on a memory timeout.
//   - Keeps saturating stall/flush performance counters.
// PARAMETERS
//   MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before HALT (>=1)
//   CNT_W        32  width of stall_count / flush_count
// PORTS
//   clk            in   1      clock, all state updates on rising edge
//   reset          in   1      synchronous, active-high
//   ifid_rn        in   5      Rn field of instruction in ID
//   ifid_rm        in   5      Rm field of instruction in ID
//   ifid_uses_rm   in   1      1 = ID instruction reads Rm (R-type, STUR data, CBZ)
//   idex_rd        in   5      destination reg of instruction in EX
//   idex_memtoreg  in   1      EX instruction is a load (LDUR)
//   br_taken       in   1      branch resolved taken in EX this cycle
//   exmem_memacc   in   1      MEM-stage instruction accesses data memory (MemWrite|MemToReg)
//   mem_ready      in   1      data memory completes access this cycle
//   pc_enable      out  1      PC register load enable
//   ifid_enable    out  1      IF/ID enable
//   idex_enable    out  1      ID/EX enable
//   exmem_enable   out  1      EX/MEM enable
//   memwr_enable   out  1      MEM/WR enable
//   ifid_flush     out  1      load NOP into IF/ID on this edge (meaningful only with ifid_enable=1)
//   idex_flush     out  1      zero ID/EX control bits on this edge (bubble)
//   halted         out  1      pipeline frozen after memory timeout
//   stall_count    out  CNT_W  cycles with a load-use bubble or freeze
//   flush_count    out  CNT_W  taken-branch flush events
// BEHAVIOUR
//   States: RUN, MEM_WAIT, HALT. State reset value is RUN; halted=0; both counters 0.
//   While reset=1: all enables 0, both flushes 0.
//   Combinational terms (outputs are Mealy: a function of state and current inputs):
//   - freeze = (state==MEM_WAIT | state==RUN) & exmem_memacc & !mem_ready.
//   - lu = idex_memtoreg & idex_rd!=31 & (idex_rd==ifid_rn | (ifid_uses_rm & idex_rd==ifid_rm)).
//   - Register 31 (XZR) never creates a hazard.
//   Output priority, highest first:
//   1) HALT: all enables 0, flushes 0, halted=1.
//   2) freeze: all five enables 0, flushes 0. A br_taken seen during freeze is ignored; it is
//      re-presented after release, because EX is held.
//   3) br_taken: all enables 1; ifid_flush=1, idex_flush=1. The load-use hazard is discarded,
//      since the ID instruction is flushed. flush_count += 1.
//   4) lu: pc_enable=0, ifid_enable=0, all other enables 1, idex_flush=1 (one bubble).
//      The hazard clears itself next cycle once the load reaches MEM.
//   5) otherwise: all enables 1, flushes 0.
//   stall_count += 1 in every cycle where case 2 or 4 applies.
//   Counters saturate at 2^CNT_W-1 and do not wrap.
//   Transitions:
//   - RUN -> MEM_WAIT when freeze.
//   - MEM_WAIT -> RUN on the cycle mem_ready=1; that cycle uses normal priority 3-5 and the pipeline advances.
//   - MEM_WAIT -> HALT when the wait counter reaches MEM_TIMEOUT with mem_ready still 0.
//   - HALT is left only by reset.
//   Wait counter ($clog2(MEM_TIMEOUT+1) bits):
//   - Cleared on reset and on entry to MEM_WAIT.
//   - Increments each MEM_WAIT cycle.
//   - Single-cycle memory (mem_ready=1 whenever exmem_memacc=1) never leaves RUN and adds zero stalls.
//   Reset asserted in any state, including mid-wait or HALT:
//   - Next state is RUN and counters clear.
//   - No pending flush or stall is remembered.
// TESTING
//   - Load-use: LDUR X1 in EX (idex_rd=1, memtoreg=1), ID has ifid_rn=1 -> one cycle pc/ifid_enable=0,
//     idex_flush=1; next cycle all enables 1; stall_count=1.
//   - XZR / no-use: idex_rd=31 with ifid_rn=31, or idex_rd=2 with ifid_rm=2 and ifid_uses_rm=0
//     -> no stall, all enables 1.
//   - Branch and load-use in the same cycle (br_taken=1, lu true) -> ifid_flush=idex_flush=1,
//     all enables 1, flush_count=1, stall_count unchanged.
//   - Memory wait: exmem_memacc=1, mem_ready low for 3 cycles then high -> 3 cycles all enables 0,
//     4th cycle advances, state RUN; stall_count=3; a br_taken held through the wait flushes only
//     in the 4th cycle.
//   - Timeout (MEM_TIMEOUT=4): mem_ready held 0 -> HALT after the wait counter reaches 4; halted=1,
//     enables stay 0 even after mem_ready=1; reset -> RUN, counters 0.
//   - Saturation (CNT_W=3): 10 consecutive load-use stall cycles -> stall_count stops at 7.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundles the hazard controller's pipeline-side inputs and the stage
// enable/flush/status outputs. The master drives inputs; the slave (controller) drives outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       ifid_rn;
  logic [4:0]       ifid_rm;
  logic             ifid_uses_rm;
  logic [4:0]       idex_rd;
  logic             idex_memtoreg;
  logic             br_taken;
  logic             exmem_memacc;
  logic             mem_ready;

  logic             pc_enable;
  logic             ifid_enable;
  logic             idex_enable;
  logic             exmem_enable;
  logic             memwr_enable;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ifid_rn, ifid_rm, ifid_uses_rm, idex_rd, idex_memtoreg,
           br_taken, exmem_memacc, mem_ready,
    input  pc_enable, ifid_enable, idex_enable, exmem_enable, memwr_enable,
           ifid_flush, idex_flush, halted, stall_count, flush_count
  );

  modport slave (
    input  ifid_rn, ifid_rm, ifid_uses_rm, idex_rd, idex_memtoreg,
           br_taken, exmem_memacc, mem_ready,
    output pc_enable, ifid_enable, idex_enable, exmem_enable, memwr_enable,
           ifid_flush, idex_flush, halted, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage CPU: stage enables/bubbles for load-use,
// taken-branch and data-memory waits, timeout halt and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic freeze;
  logic lu;
  logic stall_evt;
  logic flush_evt;
  logic [4:0] en;   // {pc, ifid, idex, exmem, memwr}
  logic ifid_fl;
  logic idex_fl;

  always_comb begin
    freeze = ((state_q == RUN) || (state_q == MEM_WAIT)) &&
             bus.exmem_memacc && !bus.mem_ready;
    lu     = bus.idex_memtoreg && (bus.idex_rd != 5'd31) &&
             ((bus.idex_rd == bus.ifid_rn) ||
              (bus.ifid_uses_rm && (bus.idex_rd == bus.ifid_rm)));
  end

  always_comb begin
    en        = '0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    if (reset || (state_q == HALT)) begin
      en = '0;
    end else if (freeze) begin
      // EX is held, so any br_taken now is seen again after release.
      stall_evt = 1'b1;
    end else if (bus.br_taken) begin
      en        = '1;
      ifid_fl   = 1'b1;
      idex_fl   = 1'b1;
      flush_evt = 1'b1;
    end else if (lu) begin
      en        = 5'b00111;
      idex_fl   = 1'b1;
      stall_evt = 1'b1;
    end else begin
      en = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_d = RUN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_d == TMO) begin
            state_d = HALT;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_evt && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
    if (flush_evt && (flush_q != '1)) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_enable    = en[4];
  assign bus.ifid_enable  = en[3];
  assign bus.idex_enable  = en[2];
  assign bus.exmem_enable = en[1];
  assign bus.memwr_enable = en[0];
  assign bus.ifid_flush   = ifid_fl;
  assign bus.idex_flush   = idex_fl;
  assign bus.halted       = (state_q == HALT);
  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;

endmodule
